splitter: RTL

SPLITTER -- requirements
Module: splitter

---
 rtl/splitter.sv | 108 ++++++++++
 1 files changed

// File: rtl/splitter.sv
// splitter: breaks one wide input word into ITEM_COUNT narrow items and emits
// them item 0 first, one per cycle, with valid/ready handshakes on both sides.
// A new word can be accepted in the same cycle the last item of the held word
// leaves, so back-to-back words stream without a bubble.
// Optional feature: define SPLITTER_SKIP_ZERO_PAD_EN to drop trailing all-zero
// items of a packet's final word (emission ends at its highest nonzero item).
module splitter #(
  parameter int DATA_WIDTH = 8,
  parameter int ITEM_COUNT = 3,
  parameter int INDEX_BITS = $clog2(ITEM_COUNT + 1)
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [DATA_WIDTH*ITEM_COUNT-1:0] in_data,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic                             in_last,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             out_last
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t                                 state;
  logic [ITEM_COUNT-1:0][DATA_WIDTH-1:0]  hold_items;
  logic                                   hold_last;
  logic [INDEX_BITS-1:0]                  index;
  logic [INDEX_BITS-1:0]                  end_idx;
  logic [INDEX_BITS-1:0]                  new_end;
  logic [DATA_WIDTH-1:0]                  item;
  logic                                   accept;
  logic                                   take;
  logic                                   final_item;

  // Index of the item that closes the incoming word; computed at latch time
  // so the emit path only needs an equality compare.
  always_comb begin
    new_end = INDEX_BITS'(ITEM_COUNT - 1);
`ifdef SPLITTER_SKIP_ZERO_PAD_EN
    if (in_last) begin
      new_end = '0;
      for (int k = 0; k < ITEM_COUNT; k++) begin
        if (in_data[k*DATA_WIDTH +: DATA_WIDTH] != '0) new_end = INDEX_BITS'(k);
      end
    end
`endif
  end

  // Select the current item from the held word.
  always_comb begin
    item = '0;
    for (int k = 0; k < ITEM_COUNT; k++) begin
      if (index == INDEX_BITS'(k)) item = hold_items[k];
    end
  end

  assign out_valid  = (state == EMIT);
  assign final_item = (index == end_idx);
  assign take       = out_valid && out_ready;
  assign out_data   = out_valid ? item : '0;
  assign out_last   = out_valid && hold_last && final_item;
  // Ready in IDLE, or while the final item is leaving (same-cycle handoff).
  assign in_ready   = !reset && ((state == IDLE) || (take && final_item));
  assign accept     = in_valid && in_ready;

  // Word/item sequencing: latch on accept, step index per transfer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      hold_items <= '0;
      hold_last  <= 1'b0;
      index      <= '0;
      end_idx    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            hold_items <= in_data;
            hold_last  <= in_last;
            end_idx    <= new_end;
            index      <= '0;
            state      <= EMIT;
          end
        end
        EMIT: begin
          if (take) begin
            if (final_item) begin
              index <= '0;
              if (accept) begin
                hold_items <= in_data;
                hold_last  <= in_last;
                end_idx    <= new_end;
              end else begin
                state <= IDLE;
              end
            end else begin
              index <= index + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
